cpu_trace_buffer: RTL and testbench

- Synthesizable commit-trace capture unit attached beside the cpu core.
- Records the PC and register writeback of each retired instruction into a circular buffer.
- Arms, triggers on a programmable PC match, captures a programmable number of post-trigger entries, then freezes for readout.
- Replaces ad-hoc monitor printing with a parametrised, depth-configurable hardware trace that a bench or debug port can read back.

---
 rtl/cpu_trace_buffer.sv | 135 +++++++++++++
 tb/tb_cpu_trace_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: commit-trace capture beside the cpu core.
// Retired instructions (PC plus writeback) are recorded into a circular
// buffer once armed. A PC match triggers the capture, a programmable number
// of post-trigger entries is kept, and then the buffer freezes for readout.
// Optional build macro TRACE_TIMESTAMP_EN adds a 32-bit cycle timestamp to
// each entry; the timestamp occupies the MSBs of rd_entry.
module cpu_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
`ifdef TRACE_TIMESTAMP_EN
  localparam int EW   = 2*XLEN+38
`else
  localparam int EW   = 2*XLEN+6
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            commit_we,
  input  logic [4:0]      commit_rd,
  input  logic [XLEN-1:0] commit_data,
  input  logic            arm,
  input  logic [XLEN-1:0] trig_pc,
  input  logic [AW-1:0]   post_cnt,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_idx,
  output logic            rd_valid,
  output logic [EW-1:0]   rd_entry,
  output logic [1:0]      state,
  output logic [AW:0]     count,
  output logic [AW-1:0]   trig_pos
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] ONE  = AW'(1);

  logic [EW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] trig_slot;
  logic [AW-1:0] remaining;

  logic [AW-1:0] oldest;
  logic [AW-1:0] next_ptr;
  logic [AW-1:0] next_oldest;
  logic [AW-1:0] done_slot;
  logic [AW-1:0] rd_slot;
  logic [AW:0]   next_count;
  logic          do_write;
  logic          pc_hit;
  logic          finish;
  logic [EW-1:0] wr_entry;

  // Write qualification, trigger detection and the index arithmetic around the ring
  always_comb begin
    do_write    = commit_valid && !arm && (state == S_ARMED || state == S_POST);
    pc_hit      = (state == S_ARMED) && (commit_pc == trig_pc);
    finish      = do_write && ((pc_hit && (post_cnt <= ONE)) ||
                               (state == S_POST && remaining == ONE));
    oldest      = (count < FULL) ? '0 : wr_ptr;
    next_ptr    = wr_ptr + ONE;
    next_count  = (count == FULL) ? count : count + (AW+1)'(1);
    next_oldest = (next_count < FULL) ? '0 : next_ptr;
    done_slot   = (state == S_ARMED) ? wr_ptr : trig_slot;
    rd_slot     = oldest + rd_idx;
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] timestamp;

  // Free-running cycle counter, restarted by arm so timestamps are relative to it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   timestamp <= '0;
    else if (arm) timestamp <= '0;
    else          timestamp <= timestamp + 32'd1;
  end

  assign wr_entry = {timestamp, commit_pc, commit_we, commit_rd, commit_data};
`else
  assign wr_entry = {commit_pc, commit_we, commit_rd, commit_data};
`endif

  // Trace RAM: contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= wr_entry;
  end

  // Capture state machine, write pointer, fill count and trigger bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      trig_pos  <= '0;
      trig_slot <= '0;
      remaining <= '0;
    end else if (arm) begin
      state  <= S_ARMED;
      wr_ptr <= '0;
      count  <= '0;
    end else if (do_write) begin
      wr_ptr <= next_ptr;
      count  <= next_count;
      if (finish) begin
        state    <= S_DONE;
        trig_pos <= done_slot - next_oldest;
      end else if (pc_hit) begin
        state     <= S_POST;
        trig_slot <= wr_ptr;
        remaining <= post_cnt - ONE;
      end else if (state == S_POST) begin
        remaining <= remaining - ONE;
      end
    end
  end

  // Registered readout relative to the oldest entry; slots past count read as zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_entry <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_entry <= ({1'b0, rd_idx} < count) ? mem[rd_slot] : '0;
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: scoreboard bench for cpu_trace_buffer (default build).
// A queue-based model of the trace history predicts state, fill count,
// trigger position and every readout; a monitor compares after each edge.
module tb_cpu_trace_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int EW    = 2*XLEN+6;

  logic            clk = 1'b0;
  logic            reset;
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            commit_we;
  logic [4:0]      commit_rd;
  logic [XLEN-1:0] commit_data;
  logic            arm;
  logic [XLEN-1:0] trig_pc;
  logic [AW-1:0]   post_cnt;
  logic            rd_en;
  logic [AW-1:0]   rd_idx;
  logic            rd_valid;
  logic [EW-1:0]   rd_entry;
  logic [1:0]      state;
  logic [AW:0]     count;
  logic [AW-1:0]   trig_pos;

  cpu_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_we(commit_we),
    .commit_rd(commit_rd), .commit_data(commit_data),
    .arm(arm), .trig_pc(trig_pc), .post_cnt(post_cnt),
    .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_entry(rd_entry),
    .state(state), .count(count), .trig_pos(trig_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    int         cnt;
    int         tpos;
    bit         rv;
  } status_t;

  status_t       status_q[$];
  logic [EW-1:0] read_q[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
  bit            mon_en = 0;

  // Reference model: the last DEPTH recorded entries, oldest first
  logic [EW-1:0] hist[$];
  int            m_phase = 0;
  int            m_trig  = 0;
  int            m_left  = 0;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit v, input logic [XLEN-1:0] pc, input logic [EW-1:0] ent,
                            input bit a, input logic [XLEN-1:0] tpc, input int post);
    if (a) begin
      hist.delete();
      m_phase = 1;
    end else if ((m_phase == 1 || m_phase == 2) && v) begin
      hist.push_back(ent);
      if (hist.size() > DEPTH) begin
        hist.delete(0);
        m_trig--;
      end
      if (m_phase == 1 && pc == tpc) begin
        m_trig  = hist.size() - 1;
        m_left  = ((post == 0) ? 1 : post) - 1;
        m_phase = (m_left == 0) ? 3 : 2;
      end else if (m_phase == 2) begin
        m_left--;
        if (m_left == 0) m_phase = 3;
      end
    end
  endtask

  // Drives one cycle of inputs at the falling edge and queues what the DUT must show after the next rising edge
  task automatic apply_stimulus(input bit v, input logic [XLEN-1:0] pc, input bit we,
                                input logic [4:0] rd, input logic [XLEN-1:0] data,
                                input bit a, input logic [XLEN-1:0] tpc, input logic [AW-1:0] post,
                                input bit re, input logic [AW-1:0] ridx);
    status_t       s;
    logic [EW-1:0] ent;
    @(negedge clk);
    commit_valid = v;  commit_pc = pc;  commit_we = we;  commit_rd = rd;
    commit_data  = data;  arm = a;  trig_pc = tpc;  post_cnt = post;
    rd_en = re;  rd_idx = ridx;
    ent = {pc, we, rd, data};
    if (re) begin
      if (int'(ridx) < hist.size()) read_q.push_back(hist[ridx]);
      else                          read_q.push_back('0);
    end
    model_step(v, pc, ent, a, tpc, int'(post));
    s.st   = 2'(m_phase);
    s.cnt  = hist.size();
    s.tpos = m_trig;
    s.rv   = re;
    status_q.push_back(s);
  endtask

  task automatic idle_cycle(input bit re, input logic [AW-1:0] ridx);
    apply_stimulus(0, '0, 0, '0, '0, 0, trig_pc, post_cnt, re, ridx);
  endtask

  task automatic commit_pc_only(input logic [XLEN-1:0] pc);
    apply_stimulus(1, pc, 0, '0, '0, 0, trig_pc, post_cnt, 0, '0);
  endtask

  // Monitor: compares the queued expectations one step after each rising edge
  initial begin
    status_t s;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && status_q.size() > 0) begin
        s = status_q.pop_front();
        check_output("state", state, s.st);
        check_output("count", count, s.cnt);
        check_output("rd_valid", rd_valid, s.rv);
        if (s.st == 2'd3) check_output("trig_pos", trig_pos, s.tpos);
        if (s.rv && read_q.size() > 0) check_output("rd_entry", rd_entry, read_q.pop_front());
      end
    end
  end

  // Directed scenarios followed by a randomized run
  initial begin
    logic [XLEN-1:0] rtpc;
    logic [AW-1:0]   rpost;
    reset = 1'b0;
    commit_valid = 0; commit_pc = '0; commit_we = 0; commit_rd = '0; commit_data = '0;
    arm = 0; trig_pc = '0; post_cnt = '0; rd_en = 0; rd_idx = '0;
    #2;
    check_output("reset_state", state, 2'd0);
    check_output("reset_count", count, 0);
    check_output("reset_rd_valid", rd_valid, 1'b0);
    #21 reset = 1'b1;
    mon_en = 1;

    // No-wrap trigger
    apply_stimulus(0, '0, 0, '0, '0, 1, 32'h10, 4'd3, 0, '0);
    for (int i = 0; i < 7; i++) commit_pc_only(32'(4*i));
    idle_cycle(1, 4'd0);
    idle_cycle(1, 4'd6);
    check_output("nowrap_state", state, 2'd3);
    check_output("nowrap_count", count, 7);
    check_output("nowrap_trig_pos", trig_pos, 4);
    check_output("nowrap_idx0_pc", rd_entry[EW-1 -: XLEN], 32'h0);
    idle_cycle(0, '0);
    check_output("nowrap_idx6_pc", rd_entry[EW-1 -: XLEN], 32'h18);

    // Wrap-around trigger
    apply_stimulus(0, '0, 0, '0, '0, 1, 32'h100, 4'd4, 0, '0);
    for (int i = 0; i < 68; i++) commit_pc_only(32'(4*i));
    idle_cycle(1, 4'd0);
    idle_cycle(1, 4'd15);
    check_output("wrap_state", state, 2'd3);
    check_output("wrap_count", count, 16);
    check_output("wrap_trig_pos", trig_pos, 12);
    check_output("wrap_idx0_pc", rd_entry[EW-1 -: XLEN], 32'hD0);
    idle_cycle(0, '0);
    check_output("wrap_idx15_pc", rd_entry[EW-1 -: XLEN], 32'h10C);

    // Writeback fields
    apply_stimulus(0, '0, 0, '0, '0, 1, 32'hFFF, 4'd2, 0, '0);
    apply_stimulus(1, 32'h8, 1, 5'd5, 32'hDEADBEEF, 0, 32'hFFF, 4'd2, 0, '0);
    idle_cycle(1, 4'd0);
    idle_cycle(0, '0);
    check_output("wb_entry", rd_entry, {32'h8, 1'b1, 5'd5, 32'hDEADBEEF});

    // Arm colliding with a matching commit
    apply_stimulus(1, 32'h40, 1, 5'd1, 32'h1, 1, 32'h40, 4'd1, 0, '0);
    idle_cycle(1, 4'd3);
    check_output("collide_state", state, 2'd1);
    check_output("collide_count", count, 0);
    idle_cycle(0, '0);
    check_output("beyond_count_entry", rd_entry, '0);

    // Reset in the middle of POST
    apply_stimulus(0, '0, 0, '0, '0, 1, 32'h0, 4'd10, 0, '0);
    commit_pc_only(32'h0);
    commit_pc_only(32'h4);
    idle_cycle(1, 4'd0);
    @(negedge clk);
    mon_en = 0;
    status_q.delete();
    read_q.delete();
    commit_valid = 0; arm = 0; rd_en = 0;
    #2 reset = 1'b0;
    #20;
    check_output("midpost_reset_state", state, 2'd0);
    check_output("midpost_reset_count", count, 0);
    check_output("midpost_reset_rd_valid", rd_valid, 1'b0);
    reset = 1'b1;
    hist.delete();
    m_phase = 0;
    m_trig  = 0;
    mon_en  = 1;
    idle_cycle(1, 4'd0);
    idle_cycle(0, '0);
    check_output("post_reset_read", rd_entry, '0);

    // Randomized traffic
    rtpc  = 32'h20;
    rpost = 4'd5;
    for (int c = 0; c < 3000; c++) begin
      bit a;
      a = ($urandom_range(0, 59) == 0);
      if (a) begin
        rtpc  = 32'(4 * $urandom_range(0, 23));
        rpost = 4'($urandom_range(0, 15));
      end
      apply_stimulus($urandom_range(0, 3) != 0, 32'(4 * $urandom_range(0, 23)),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                     a, rtpc, rpost, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
    end
    idle_cycle(0, '0);
    idle_cycle(0, '0);
    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
